instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Memory-side responder for the CPU instruction-fetch handshake (readM / address / data / inputReady).
- Accepts a read request, waits a configurable latency, then drives the addressed word onto the shared data bus and pulses inputReady.
- Backed by a synchronous-write word array, which the testbench or loader preloads through a dedicated load port.
- Sits between the cpu and the test harness; replaces ad-hoc behavioural memory in simulation.

Parameters:
- WORD_SIZE, 16, data and address width.
- ADDR_BITS, 8, array index width; the array holds 2^ADDR_BITS words.
- READ_LATENCY, 1, cycles from request acceptance to data driven; legal values 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- readM  input  1  read request from the cpu.
- address  input  WORD_SIZE  read address; only bits [ADDR_BITS-1:0] are used.
- data  inout  WORD_SIZE  shared data bus; driven only in DRIVE and READY, otherwise high-Z.
- inputReady  output  1  data-valid strobe to the cpu; registered.
- load_en  input  1  preload write enable.
- load_addr  input  ADDR_BITS  preload index.
- load_data  input  WORD_SIZE  preload word.
- busy  output  1  high in every state except IDLE.
- num_served  output  WORD_SIZE  count of completed responses; wraps modulo 2^16.

Behaviour:
- Reset (reset_n low at an edge):
  - state goes to IDLE; inputReady=0, busy=0, num_served=0, data=Z.
  - Array contents are not cleared.
  - Reset applied in any state aborts the in-flight request with no inputReady pulse.
- States: IDLE, WAIT, DRIVE, READY, GAP.
- IDLE: if readM=1 at an edge, accept the request.
  - Latch rd_word = array[address[ADDR_BITS-1:0]] at that edge.
  - Go to WAIT with wait_cnt=READ_LATENCY-1, or go straight to DRIVE if READ_LATENCY=1.
  - If readM=0, stay in IDLE.
- WAIT: decrement wait_cnt each cycle; when it reaches 0, go to DRIVE. readM is ignored here.
- DRIVE: data=rd_word, inputReady=0. This is one cycle of setup before the strobe, because the cpu samples data on the rising edge of inputReady. Next state is READY.
- READY: data=rd_word, inputReady=1 for exactly one cycle; num_served increments. Next state is GAP.
- GAP: data=Z, inputReady=0. This cycle lets the cpu re-present readM. Next state is IDLE.
- Timing: with acceptance at edge E, data is driven after edge E+READ_LATENCY-1 and inputReady is high after edge E+READ_LATENCY. Minimum request period is READ_LATENCY+3 cycles.
- The read value is the snapshot taken at acceptance. A load to the same index during WAIT/DRIVE/READY does not alter the returned word.
- Load port:
  - array[load_addr] <= load_data at any edge where load_en=1 and reset_n=1, in every state.
  - A load and an acceptance in the same cycle to the same index return the old word; the write lands after the snapshot.
- Address bits above ADDR_BITS are ignored, so addresses wrap onto the array.
- readM dropping mid-transaction does not cancel the transaction.
- The response always completes unless reset intervenes.
- inputReady and busy come from registers, not from combinational logic.

Decomposition:
- Package instr_mem_pkg holds:
  - state encoding constants (IDLE=0, WAIT=1, DRIVE=2, READY=3, GAP=4, 3-bit);
  - WORD_SIZE;
  - the default READ_LATENCY.
- Sub-module mem_array holds the word array.
  - 2^ADDR_BITS x WORD_SIZE.
  - One synchronous write port and one combinational read port.
  - No reset.
- The FSM, wait counter, rd_word register, tri-state driver and num_served counter stay in instr_mem_responder.

Test Plan:
1. Basic read, READ_LATENCY=1: preload array[3]=16'hA5C3, then hold readM=1 with address=3 in IDLE. Required: data=A5C3 after the accept edge, one inputReady pulse on the next cycle, num_served=1, then data=Z in GAP.
2. Latency, READ_LATENCY=4: same request. Required: inputReady rises exactly 4 edges after acceptance, and busy stays high for 6 cycles.
3. Reset in WAIT, READ_LATENCY=4: assert reset_n=0 two cycles after acceptance. Required: no inputReady pulse, data=Z, num_served=0, and array[3] still returns A5C3 on the next request.
4. Snapshot rule: accept a read of index 7 (value 16'h1111); in the next WAIT cycle load array[7]=16'h2222. Required: the response is 1111, and a second read returns 2222.
5. Address wrap, ADDR_BITS=8: preload array[8'h05]=16'hBEEF and request address 16'h0105. Required: data=BEEF.
6. Back-to-back: readM held high continuously at addresses 0,1,2 (array = 10,20,30), READ_LATENCY=1. Required: three inputReady pulses spaced 4 cycles apart carrying 10, 20, 30, and num_served=3.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// State encoding, bus width and default read latency.
package instr_mem_pkg;

  localparam int WORD_SIZE        = 16;
  localparam int READ_LATENCY_DEF = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    DRIVE = 3'd2,
    READY = 3'd3,
    GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word array: one synchronous write port, one combinational read port.
// Contents are never reset so a preload survives a responder reset.
module mem_array #(
  parameter int W         = 16,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] mem [2**ADDR_BITS];

  // preload write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the cpu fetch handshake.
// Snapshots the word at acceptance, waits, drives data, then strobes.
module instr_mem_responder #(
  parameter int WORD_SIZE    = instr_mem_pkg::WORD_SIZE,
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = instr_mem_pkg::READ_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] num_served
);

  import instr_mem_pkg::*;

  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_t               state;
  state_t               next_state;
  logic [3:0]           wait_cnt;
  logic [3:0]           wait_nxt;
  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 drive_en;
  logic                 accept;

  // high address bits fold onto the array
  logic unused_hi;
  assign unused_hi = ^address[WORD_SIZE-1:ADDR_BITS];

  assign accept = (state == IDLE) && readM;

  mem_array #(
    .W         (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (load_en & reset_n),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (address[ADDR_BITS-1:0]),
    .rdata (mem_rdata)
  );

  // state, counter and registered strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      inputReady <= 1'b0;
      busy       <= 1'b0;
      num_served <= '0;
    end else begin
      state      <= next_state;
      wait_cnt   <= wait_nxt;
      inputReady <= (next_state == READY);
      busy       <= (next_state != IDLE);
      if (next_state == READY)
        num_served <= num_served + WORD_SIZE'(1);
    end
  end

  // snapshot taken before any same-edge load lands
  always_ff @(posedge clk) begin
    if (reset_n && accept) rd_word <= mem_rdata;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    wait_nxt   = wait_cnt;
    unique case (state)
      IDLE: begin
        if (readM) begin
          if (READ_LATENCY == 1) begin
            next_state = DRIVE;
          end else begin
            next_state = WAIT;
            wait_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        wait_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) next_state = DRIVE;
      end
      DRIVE:   next_state = READY;
      READY:   next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // bus drive enable
  always_comb begin
    drive_en = (state == DRIVE) || (state == READY);
  end

  assign data = drive_en ? rd_word : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: one responder at latency 1, one at latency 4.
// Bus pull-ups make an undriven bus read as all ones.
module tb_instr_mem_responder;

  localparam logic [15:0] ZVAL = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  logic        rd1, rd4;
  logic [15:0] addr1, addr4;
  wire  [15:0] data1, data4;
  logic        ir1, ir4;
  logic        busy1, busy4;
  logic [15:0] num1, num4;

  int tests = 0;
  int fails = 0;

  pullup pu1 (data1);
  pullup pu4 (data4);

  always #5 clk = ~clk;

  instr_mem_responder #(
    .WORD_SIZE (16), .ADDR_BITS (8), .READ_LATENCY (1)
  ) d1 (
    .clk (clk), .reset_n (reset_n), .readM (rd1),
    .address (addr1), .data (data1), .inputReady (ir1),
    .load_en (load_en), .load_addr (load_addr),
    .load_data (load_data), .busy (busy1), .num_served (num1)
  );

  instr_mem_responder #(
    .WORD_SIZE (16), .ADDR_BITS (8), .READ_LATENCY (4)
  ) d4 (
    .clk (clk), .reset_n (reset_n), .readM (rd4),
    .address (addr4), .data (data4), .inputReady (ir4),
    .load_en (load_en), .load_addr (load_addr),
    .load_data (load_data), .busy (busy4), .num_served (num4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    tests++;
    if ({ir1, busy1, ir4, busy4} !== 4'b0) begin
      fails++;
      $display("FAIL rst_strobes got %b want 0000",
               {ir1, busy1, ir4, busy4});
    end
    tests++;
    if (num1 !== 16'd0 || num4 !== 16'd0) begin
      fails++;
      $display("FAIL rst_num got %h/%h want 0/0", num1, num4);
    end
    tests++;
    if (data1 !== ZVAL || data4 !== ZVAL) begin
      fails++;
      $display("FAIL rst_data got %h/%h want %h", data1, data4, ZVAL);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load(8'd3, 16'hA5C3);
    rd1 = 1'b1; addr1 = 16'd3;
    tick();
    rd1 = 1'b0;
    tests++;
    if (data1 !== 16'hA5C3 || ir1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_drive got %h ir=%b want a5c3 ir=0", data1, ir1);
    end
    tick();
    tests++;
    if (ir1 !== 1'b1 || data1 !== 16'hA5C3 || num1 !== 16'd1) begin
      fails++;
      $display("FAIL basic_ready got ir=%b %h n=%0d want ir=1 a5c3 n=1",
               ir1, data1, num1);
    end
    tick();
    tests++;
    if (ir1 !== 1'b0 || data1 !== ZVAL || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL basic_gap got ir=%b %h busy=%b want ir=0 %h busy=1",
               ir1, data1, busy1, ZVAL);
    end
    tick();
    tests++;
    if (busy1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle busy got %b want 0", busy1);
    end
  endtask

  task automatic test_latency();
    int rise = -1;
    int bcnt = 0;
    logic [15:0] pre = 16'h0;
    rd4 = 1'b1; addr4 = 16'd3;
    tick();
    rd4 = 1'b0;
    if (busy4) bcnt++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) pre = data4;
      if (ir4 && rise < 0) rise = k;
      if (busy4) bcnt++;
    end
    tests++;
    if (rise != 4) begin
      fails++;
      $display("FAIL lat_rise got %0d want 4", rise);
    end
    tests++;
    if (bcnt != 6) begin
      fails++;
      $display("FAIL lat_busy got %0d want 6", bcnt);
    end
    tests++;
    if (pre !== 16'hA5C3) begin
      fails++;
      $display("FAIL lat_setup got %h want a5c3", pre);
    end
  endtask

  task automatic test_reset_wait();
    int seen = 0;
    int zbad = 0;
    rd4 = 1'b1; addr4 = 16'd3;
    tick();
    rd4 = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    if (ir4) seen++;
    if (data4 !== ZVAL) zbad++;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ir4) seen++;
      if (data4 !== ZVAL) zbad++;
    end
    tests++;
    if (seen != 0 || zbad != 0) begin
      fails++;
      $display("FAIL rstw_abort got pulses=%0d driven=%0d want 0/0",
               seen, zbad);
    end
    tests++;
    if (num4 !== 16'd0 || busy4 !== 1'b0) begin
      fails++;
      $display("FAIL rstw_num got n=%0d busy=%b want 0/0", num4, busy4);
    end
    rd4 = 1'b1; addr4 = 16'd3;
    tick();
    rd4 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (ir4 !== 1'b1 || data4 !== 16'hA5C3 || num4 !== 16'd1) begin
      fails++;
      $display("FAIL rstw_again got ir=%b %h n=%0d want 1 a5c3 1",
               ir4, data4, num4);
    end
    tick(); tick();
  endtask

  task automatic test_snapshot();
    load(8'd7, 16'h1111);
    rd4 = 1'b1; addr4 = 16'd7;
    tick();
    rd4 = 1'b0;
    load(8'd7, 16'h2222);
    for (int k = 0; k < 3; k++) tick();
    tests++;
    if (ir4 !== 1'b1 || data4 !== 16'h1111) begin
      fails++;
      $display("FAIL snap_old got ir=%b %h want 1 1111", ir4, data4);
    end
    tick(); tick();
    rd4 = 1'b1;
    tick();
    rd4 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (ir4 !== 1'b1 || data4 !== 16'h2222 || num4 !== 16'd3) begin
      fails++;
      $display("FAIL snap_new got ir=%b %h n=%0d want 1 2222 3",
               ir4, data4, num4);
    end
    tick(); tick();
  endtask

  task automatic test_wrap();
    load(8'h05, 16'hBEEF);
    load(8'h01, 16'h0BAD);
    rd1 = 1'b1; addr1 = 16'h0105;
    tick();
    rd1 = 1'b0;
    tests++;
    if (data1 !== 16'hBEEF) begin
      fails++;
      $display("FAIL wrap_data got %h want beef", data1);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    int t [3];
    logic [15:0] v [3];
    int n = 0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    load(8'd0, 16'd10);
    load(8'd1, 16'd20);
    load(8'd2, 16'd30);
    rd1 = 1'b1; addr1 = 16'd0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ir1 && n < 3) begin
        t[n] = c; v[n] = data1; n++;
      end
      addr1 = 16'((c + 1) / 4);
      if (c >= 8) rd1 = 1'b0;
    end
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL b2b_count got %0d want 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (t[i] != 1 + 4 * i || v[i] !== 16'(10 * (i + 1))) begin
          fails++;
          $display("FAIL b2b_pulse%0d got c=%0d %0d want c=%0d %0d",
                   i, t[i], v[i], 1 + 4 * i, 10 * (i + 1));
        end
      end
    end
    tests++;
    if (num1 !== 16'd3) begin
      fails++;
      $display("FAIL b2b_num got %0d want 3", num1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rd1 = 1'b0; rd4 = 1'b0;
    addr1 = '0; addr4 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    test_reset();
    test_basic();
    test_latency();
    test_reset_wait();
    test_snapshot();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
